fifo_dual_ported: RTL and testbench

Synchronous FIFO with two write ports and two read ports. It can accept up to two entries and retire up to two entries per cycle, in strict order. The block is generic over the entry width. The memory controller uses it as its request queue: port 1 carries the primary request, port 2 the secondary one, and a single pop is served per cycle.

---
 rtl/fifo_dual_ported.sv | 87 ++++++++
 tb/tb_fifo_dual_ported.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fifo_dual_ported.sv
// Dual-write/dual-read in-order FIFO; outputs are show-ahead from registered state.
// Latency: a pushed entry appears on pop_data_1 one cycle after the push.
// Backpressure: ready_1/ready_2 reflect free space before any pop; a push while not ready is dropped.
module fifo_dual_ported #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_flush,
  input  logic          push_1,
  output logic          ready_1,
  input  logic [DW-1:0] push_data_1,
  input  logic          push_2,
  output logic          ready_2,
  input  logic [DW-1:0] push_data_2,
  output logic [DW-1:0] pop_data_1,
  output logic          valid_1,
  input  logic          pop_1,
  output logic [DW-1:0] pop_data_2,
  output logic          valid_2,
  input  logic          pop_2
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] free_slots;

  logic          acc_1;
  logic          acc_2;
  logic          pop_ok_1;
  logic          pop_ok_2;
  logic [1:0]    n_push;
  logic [1:0]    n_pop;
  logic [AW-1:0] head_plus_1;
  logic [AW-1:0] tail_plus_1;
  logic [AW-1:0] wr_addr_2;
  logic          clear;

  assign free_slots  = DEPTH_C - count;
  assign ready_1     = free_slots >= CW'(1);
  assign ready_2     = free_slots >= CW'(2);
  assign valid_1     = count >= CW'(1);
  assign valid_2     = count >= CW'(2);

  assign head_plus_1 = head + AW'(1);
  assign tail_plus_1 = tail + AW'(1);
  assign pop_data_1  = mem[head];
  assign pop_data_2  = mem[head_plus_1];

  assign clear       = rst | valid_flush;
  assign acc_1       = push_1 & ready_1;
  assign acc_2       = push_2 & ready_2;
  // The second pop only retires together with the first, so order is never broken.
  assign pop_ok_1    = pop_1 & valid_1;
  assign pop_ok_2    = pop_2 & valid_2 & pop_ok_1;
  assign n_push      = {acc_1 & acc_2, acc_1 ^ acc_2};
  assign n_pop       = {pop_ok_1 & pop_ok_2, pop_ok_1 ^ pop_ok_2};
  assign wr_addr_2   = acc_1 ? tail_plus_1 : tail;

  always_ff @(posedge clk) begin
    if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_pop);
      tail  <= tail + AW'(n_push);
      count <= count + CW'(n_push) - CW'(n_pop);
    end
  end

  // Storage is deliberately not reset; valid_* qualify the read data.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (acc_1) mem[tail] <= push_data_1;
      if (acc_2) mem[wr_addr_2] <= push_data_2;
    end
  end

endmodule

// File: tb/tb_fifo_dual_ported.sv
// Scoreboard bench for fifo_dual_ported (DW=16, DEPTH=4): a reference queue tracks contents and order.
module tb_fifo_dual_ported;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_flush = 1'b0;
  logic          push_1 = 1'b0;
  logic          ready_1;
  logic [DW-1:0] push_data_1 = '0;
  logic          push_2 = 1'b0;
  logic          ready_2;
  logic [DW-1:0] push_data_2 = '0;
  logic [DW-1:0] pop_data_1;
  logic          valid_1;
  logic          pop_1 = 1'b0;
  logic [DW-1:0] pop_data_2;
  logic          valid_2;
  logic          pop_2 = 1'b0;

  fifo_dual_ported #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_flush (valid_flush),
    .push_1      (push_1),
    .ready_1     (ready_1),
    .push_data_1 (push_data_1),
    .push_2      (push_2),
    .ready_2     (ready_2),
    .push_data_2 (push_data_2),
    .pop_data_1  (pop_data_1),
    .valid_1     (valid_1),
    .pop_1       (pop_1),
    .pop_data_2  (pop_data_2),
    .valid_2     (valid_2),
    .pop_2       (pop_2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Check state-only outputs against the scoreboard, then drive one clock of stimulus.
  task automatic step(input string tag,
                      input logic ph1, input logic [DW-1:0] d1,
                      input logic ph2, input logic [DW-1:0] d2,
                      input logic pp1, input logic pp2, input logic fl);
    int  n;
    bit  a1, a2, p1, p2;
    n = sb.size();
    push_1 = ph1; push_data_1 = d1;
    push_2 = ph2; push_data_2 = d2;
    pop_1  = pp1; pop_2 = pp2;
    valid_flush = fl;
    chk({tag, ".ready_1"}, 32'(ready_1), 32'(n <= DEPTH - 1));
    chk({tag, ".ready_2"}, 32'(ready_2), 32'(n <= DEPTH - 2));
    chk({tag, ".valid_1"}, 32'(valid_1), 32'(n >= 1));
    chk({tag, ".valid_2"}, 32'(valid_2), 32'(n >= 2));
    if (n >= 1) chk({tag, ".pop_data_1"}, 32'(pop_data_1), 32'(sb[0]));
    if (n >= 2) chk({tag, ".pop_data_2"}, 32'(pop_data_2), 32'(sb[1]));
    a1 = ph1 && (n <= DEPTH - 1);
    a2 = ph2 && (n <= DEPTH - 2);
    p1 = pp1 && (n >= 1);
    p2 = pp2 && (n >= 2) && p1;
    if (fl) begin
      sb.delete();
    end else begin
      if (p1) void'(sb.pop_front());
      if (p2) void'(sb.pop_front());
      if (a1) sb.push_back(d1);
      if (a2) sb.push_back(d2);
    end
    @(posedge clk);
    #1;
    push_1 = 1'b0; push_2 = 1'b0; pop_1 = 1'b0; pop_2 = 1'b0; valid_flush = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2 * DEPTH && sb.size() > 0; i++)
      step(tag, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state, single push visible next cycle
    step("t1_push", 1'b1, 16'h000A, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step("t1_show", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    drain("t1_drain");

    // 2: fill with dual pushes, drop push while full, single pops in order
    step("t2_dual_a", 1'b1, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    step("t2_dual_b", 1'b1, 16'h0003, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0);
    step("t2_full",   1'b1, 16'h0005, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    drain("t2_pop");

    // 3: three held, dual push only admits port 1
    step("t3_fill_a", 1'b1, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    step("t3_fill_b", 1'b1, 16'h0003, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step("t3_one",    1'b1, 16'h0007, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0);
    step("t3_check",  1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    drain("t3_drain");

    // 4: dual pop, then pop_2 alone is ignored
    step("t4_fill_a", 1'b1, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    step("t4_fill_b", 1'b1, 16'h0003, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step("t4_dpop",   1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    step("t4_refill", 1'b1, 16'h0009, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step("t4_pop2",   1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("t4_after",  1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    drain("t4_drain");

    // 5: random traffic with wrap and simultaneous push/pop
    for (int i = 0; i < 40; i++)
      step("t5_rand", 1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), 1'b0);
    drain("t5_drain");

    // 6: flush wins over a same-cycle push
    step("t6_fill_a", 1'b1, 16'h0011, 1'b1, 16'h0012, 1'b0, 1'b0, 1'b0);
    step("t6_fill_b", 1'b1, 16'h0013, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step("t6_flush",  1'b1, 16'h00FF, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    step("t6_empty",  1'b1, 16'h0021, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step("t6_head",   1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    drain("t6_drain");

    // synchronous reset while holding entries
    step("t7_fill", 1'b1, 16'h0031, 1'b1, 16'h0032, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    step("t7_reset", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
